// File: rtl/tenyr_bus_pkg.sv
// Shared definitions for the tenyr data-memory arbiter and its picker.
package tenyr_bus_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  // Latency counter width; holds LATENCY values 1..15.
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] ACK   = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = IDLE,
    StIssue = ISSUE,
    StWait  = WAIT,
    StAck   = ACK
  } state_e;

endpackage

// File: rtl/tenyr_rr_pick.sv
// Combinational two-requester picker: round-robin on ties unless fixed priority is selected.
module tenyr_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed,
  output logic       win,
  output logic       any
);

  // On a tie, fixed priority favours requester 0; otherwise the one not served last.
  always_comb begin
    any = |req;
    win = 1'b0;
    case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = fixed ? 1'b0 : ~last;
      default: win = 1'b0;
    endcase
  end

endmodule

// File: rtl/tenyr_bus_arbiter.sv
// Two-master arbiter in front of a single-port data memory with fixed read latency.
module tenyr_bus_arbiter
  import tenyr_bus_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_strobe,
  input  logic              m0_rw,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_strobe,
  input  logic              m1_rw,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_strobe,
  output logic              s_rw,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              busy,
  output logic              grant
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
    $error("tenyr_bus_arbiter: LATENCY must lie in 1..15");
  end

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              cap0, cap1;
  logic              s_strobe_q, busy_q;
  logic [1:0]        ack_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              pick_win, pick_any;

  tenyr_rr_pick u_pick (
    .req   ({m1_strobe, m0_strobe}),
    .last  (last_q),
    .fixed (FIXED_PRIO != 0),
    .win   (pick_win),
    .any   (pick_any)
  );

  // Next-state and request-latch logic; requests are only sampled in StIdle.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    cap0    = 1'b0;
    cap1    = 1'b0;
    case (state_q)
      StIdle: begin
        if (pick_any) begin
          grant_d = pick_win;
          rw_d    = pick_win ? m1_rw    : m0_rw;
          addr_d  = pick_win ? m1_addr  : m0_addr;
          wdata_d = pick_win ? m1_wdata : m0_wdata;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = CNT_W'(LATENCY);
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == CNT_W'(1)) begin
          // Writes still spend the full latency here but leave rdata untouched.
          cap0    = ~rw_q & ~grant_q;
          cap1    = ~rw_q &  grant_q;
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StAck: begin
        last_d  = grant_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched request, latency counter and round-robin pointer (reset favours m0).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_q <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      grant_q <= grant_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Registered handshake outputs and per-master read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_strobe_q <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= 2'b00;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      s_strobe_q <= (state_d == StIssue);
      busy_q     <= (state_d != StIdle);
      ack_q[0]   <= (state_d == StAck) & ~grant_d;
      ack_q[1]   <= (state_d == StAck) &  grant_d;
      if (cap0) rdata0_q <= s_rdata;
      if (cap1) rdata1_q <= s_rdata;
    end
  end

  assign s_strobe = s_strobe_q;
  assign s_rw     = rw_q;
  assign s_addr   = addr_q;
  assign s_wdata  = wdata_q;
  assign busy     = busy_q;
  assign grant    = grant_q;
  assign m0_ack   = ack_q[0];
  assign m1_ack   = ack_q[1];
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_tenyr_bus_arbiter.sv
// Directed bench: instance a (LATENCY=1, round-robin), instance b (LATENCY=3, fixed priority).
module tb_tenyr_bus_arbiter;

  localparam logic        H     = 1'b1;
  localparam logic        L     = 1'b0;
  // Memory model returns addr ^ MEM_K; masters write addr ^ Wn_K.
  localparam logic [31:0] MEM_K = 32'hDEADBFEF;
  localparam logic [31:0] W0_K  = 32'h0F0F0F0F;
  localparam logic [31:0] W1_K  = 32'h12345658;
  localparam logic [31:0] R100  = 32'hDEADBEEF;
  localparam logic [31:0] R40   = 32'hDEADBFAF;
  localparam logic [31:0] R200  = 32'hDEADBDEF;
  localparam logic [31:0] R300  = 32'hDEADBCEF;

  typedef struct {
    logic        m0s;
    logic [31:0] m0a;
    logic        m1s;
    logic [31:0] m1a;
    logic        es;
    logic [31:0] ea;
    logic        eb;
    logic        eg;
    logic        ea0;
    logic        ea1;
    logic [31:0] er0;
    logic [31:0] er1;
  } vec_t;

  logic clk;
  int   checks;
  int   failures;

  logic        a_rst_n, a_m0_strobe, a_m0_rw, a_m0_ack, a_m1_strobe, a_m1_rw, a_m1_ack;
  logic [31:0] a_m0_addr, a_m0_wdata, a_m0_rdata, a_m1_addr, a_m1_wdata, a_m1_rdata;
  logic        a_s_strobe, a_s_rw, a_busy, a_grant;
  logic [31:0] a_s_addr, a_s_wdata, a_s_rdata;

  logic        b_rst_n, b_m0_strobe, b_m0_rw, b_m0_ack, b_m1_strobe, b_m1_rw, b_m1_ack;
  logic [31:0] b_m0_addr, b_m0_wdata, b_m0_rdata, b_m1_addr, b_m1_wdata, b_m1_rdata;
  logic        b_s_strobe, b_s_rw, b_busy, b_grant;
  logic [31:0] b_s_addr, b_s_wdata, b_s_rdata;

  assign a_m0_wdata = a_m0_addr ^ W0_K;
  assign a_m1_wdata = a_m1_addr ^ W1_K;
  assign a_s_rdata  = a_s_addr ^ MEM_K;
  assign b_m0_wdata = b_m0_addr ^ W0_K;
  assign b_m1_wdata = b_m1_addr ^ W1_K;
  assign b_s_rdata  = b_s_addr ^ MEM_K;

  tenyr_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1), .FIXED_PRIO(0)) dut_a (
    .clk(clk), .reset_n(a_rst_n),
    .m0_strobe(a_m0_strobe), .m0_rw(a_m0_rw), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata),
    .m0_ack(a_m0_ack), .m0_rdata(a_m0_rdata),
    .m1_strobe(a_m1_strobe), .m1_rw(a_m1_rw), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata),
    .m1_ack(a_m1_ack), .m1_rdata(a_m1_rdata),
    .s_strobe(a_s_strobe), .s_rw(a_s_rw), .s_addr(a_s_addr), .s_wdata(a_s_wdata),
    .s_rdata(a_s_rdata), .busy(a_busy), .grant(a_grant)
  );

  tenyr_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(3), .FIXED_PRIO(1)) dut_b (
    .clk(clk), .reset_n(b_rst_n),
    .m0_strobe(b_m0_strobe), .m0_rw(b_m0_rw), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
    .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
    .m1_strobe(b_m1_strobe), .m1_rw(b_m1_rw), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
    .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
    .s_strobe(b_s_strobe), .s_rw(b_s_rw), .s_addr(b_s_addr), .s_wdata(b_s_wdata),
    .s_rdata(b_s_rdata), .busy(b_busy), .grant(b_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic m0s, input logic [31:0] m0a, input logic m1s,
                             input logic [31:0] m1a, input logic es, input logic [31:0] ea,
                             input logic eb, input logic eg, input logic ea0, input logic ea1,
                             input logic [31:0] er0, input logic [31:0] er1);
    vec_t r;
    r.m0s = m0s; r.m0a = m0a; r.m1s = m1s; r.m1a = m1a;
    r.es = es; r.ea = ea; r.eb = eb; r.eg = eg;
    r.ea0 = ea0; r.ea1 = ea1; r.er0 = er0; r.er1 = er1;
    return r;
  endfunction

  vec_t tbl[$];
  int   strobes;
  logic exp_a0, exp_a1, exp_s, exp_g;

  initial begin
    checks = 0;
    failures = 0;
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_m0_strobe = 1'b0; a_m0_rw = 1'b0; a_m0_addr = '0;
    a_m1_strobe = 1'b0; a_m1_rw = 1'b0; a_m1_addr = '0;
    b_m0_strobe = 1'b0; b_m0_rw = 1'b0; b_m0_addr = '0;
    b_m1_strobe = 1'b0; b_m1_rw = 1'b0; b_m1_addr = '0;

    // Instance a rows: inputs this cycle | s_strobe, s_addr, busy, grant, acks, rdata.
    // Single read of 0x100.
    tbl.push_back(v(H, 32'h100, L, 32'h0,   L, 32'h0,   L, L, L, L, 32'h0, 32'h0));
    tbl.push_back(v(H, 32'h100, L, 32'h0,   H, 32'h100, H, L, L, L, 32'h0, 32'h0));
    tbl.push_back(v(H, 32'h100, L, 32'h0,   L, 32'h100, H, L, L, L, 32'h0, 32'h0));
    tbl.push_back(v(H, 32'h100, L, 32'h0,   L, 32'h100, H, L, H, L, R100,  32'h0));
    tbl.push_back(v(L, 32'h0,   L, 32'h0,   L, 32'h100, L, L, L, L, R100,  32'h0));
    // m1 read of 0x40, strobe dropped the cycle after ISSUE.
    tbl.push_back(v(L, 32'h0,   H, 32'h40,  L, 32'h100, L, L, L, L, R100,  32'h0));
    tbl.push_back(v(L, 32'h0,   H, 32'h40,  H, 32'h40,  H, H, L, L, R100,  32'h0));
    tbl.push_back(v(L, 32'h0,   L, 32'h0,   L, 32'h40,  H, H, L, L, R100,  32'h0));
    tbl.push_back(v(L, 32'h0,   L, 32'h0,   L, 32'h40,  H, H, L, H, R100,  R40));
    tbl.push_back(v(L, 32'h0,   L, 32'h0,   L, 32'h40,  L, H, L, L, R100,  R40));
    // Both held: round-robin m0, m1, m0, m1.
    tbl.push_back(v(H, 32'h200, H, 32'h300, L, 32'h40,  L, H, L, L, R100,  R40));
    tbl.push_back(v(H, 32'h200, H, 32'h300, H, 32'h200, H, L, L, L, R100,  R40));
    tbl.push_back(v(H, 32'h200, H, 32'h300, L, 32'h200, H, L, L, L, R100,  R40));
    tbl.push_back(v(H, 32'h200, H, 32'h300, L, 32'h200, H, L, H, L, R200,  R40));
    tbl.push_back(v(H, 32'h200, H, 32'h300, L, 32'h200, L, L, L, L, R200,  R40));
    tbl.push_back(v(H, 32'h200, H, 32'h300, H, 32'h300, H, H, L, L, R200,  R40));
    tbl.push_back(v(H, 32'h200, H, 32'h300, L, 32'h300, H, H, L, L, R200,  R40));
    tbl.push_back(v(H, 32'h200, H, 32'h300, L, 32'h300, H, H, L, H, R200,  R300));
    tbl.push_back(v(H, 32'h200, H, 32'h300, L, 32'h300, L, H, L, L, R200,  R300));
    tbl.push_back(v(H, 32'h200, H, 32'h300, H, 32'h200, H, L, L, L, R200,  R300));
    tbl.push_back(v(H, 32'h200, H, 32'h300, L, 32'h200, H, L, L, L, R200,  R300));
    tbl.push_back(v(H, 32'h200, H, 32'h300, L, 32'h200, H, L, H, L, R200,  R300));
    tbl.push_back(v(H, 32'h200, H, 32'h300, L, 32'h200, L, L, L, L, R200,  R300));
    tbl.push_back(v(H, 32'h200, H, 32'h300, H, 32'h300, H, H, L, L, R200,  R300));
    tbl.push_back(v(H, 32'h200, H, 32'h300, L, 32'h300, H, H, L, L, R200,  R300));
    tbl.push_back(v(L, 32'h0,   L, 32'h0,   L, 32'h300, H, H, L, H, R200,  R300));
    tbl.push_back(v(L, 32'h0,   L, 32'h0,   L, 32'h300, L, H, L, L, R200,  R300));
    tbl.push_back(v(L, 32'h0,   L, 32'h0,   L, 32'h300, L, H, L, L, R200,  R300));

    repeat (2) @(negedge clk);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;

    check("b_reset", 256'({b_s_strobe, b_s_rw, b_s_addr, b_s_wdata, b_busy, b_grant,
                           b_m0_ack, b_m1_ack, b_m0_rdata, b_m1_rdata}), 256'(0));

    for (int i = 0; i < tbl.size(); i++) begin
      check($sformatf("a_row%0d", i),
            256'({a_s_strobe, a_s_rw, a_s_addr, a_busy, a_grant, a_m0_ack, a_m1_ack,
                  a_m0_rdata, a_m1_rdata}),
            256'({tbl[i].es, 1'b0, tbl[i].ea, tbl[i].eb, tbl[i].eg, tbl[i].ea0, tbl[i].ea1,
                  tbl[i].er0, tbl[i].er1}));
      a_m0_strobe = tbl[i].m0s;
      a_m0_addr   = tbl[i].m0a;
      a_m1_strobe = tbl[i].m1s;
      a_m1_addr   = tbl[i].m1a;
      @(negedge clk);
    end

    // Instance b: m1 write of 0x12345678 to 0x20 with LATENCY=3.
    b_m1_strobe = 1'b1; b_m1_rw = 1'b1; b_m1_addr = 32'h20;
    strobes = 0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      strobes += int'(b_s_strobe);
      if (c == 1)
        check("b_wr_issue", 256'({b_s_strobe, b_s_rw, b_s_addr, b_s_wdata, b_grant}),
              256'({1'b1, 1'b1, 32'h20, 32'h12345678, 1'b1}));
      check($sformatf("b_wr_c%0d", c), 256'({b_m0_ack, b_m1_ack, b_busy, b_m1_rdata}),
            256'({1'b0, (c == 5), (c <= 5), 32'h0}));
      if (c == 5) begin
        b_m1_strobe = 1'b0;
        b_m1_rw     = 1'b0;
      end
    end
    check("b_wr_strobe_count", 256'(strobes), 256'(1));

    // Instance b: fixed priority, m0 keeps requesting through three accesses.
    b_m0_strobe = 1'b1; b_m0_addr = 32'h10;
    b_m1_strobe = 1'b1; b_m1_addr = 32'h30;
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      exp_a0 = (c == 5) || (c == 11) || (c == 17);
      exp_a1 = (c == 23);
      exp_s  = (c == 1) || (c == 7) || (c == 13) || (c == 19);
      exp_g  = (c >= 19);
      check($sformatf("b_fp_c%0d", c), 256'({b_m0_ack, b_m1_ack, b_s_strobe, b_grant}),
            256'({exp_a0, exp_a1, exp_s, exp_g}));
      if (c == 17) begin
        check("b_fp_m0_rdata", 256'(b_m0_rdata), 256'(32'hDEADBFFF));
        b_m0_strobe = 1'b0;
      end
      if (c == 23) begin
        check("b_fp_m1_rdata", 256'(b_m1_rdata), 256'(32'hDEADBFDF));
        b_m1_strobe = 1'b0;
      end
    end

    // Instance a: reset during WAIT of an m0 read.
    a_m0_strobe = 1'b1; a_m0_addr = 32'h500;
    @(negedge clk);
    @(negedge clk);
    check("a_rst_in_wait", 256'({a_busy, a_s_strobe, a_grant, a_s_addr}),
          256'({1'b1, 1'b0, 1'b0, 32'h500}));
    #2 a_rst_n = 1'b0;
    #1 check("a_rst_async", 256'({a_s_strobe, a_s_rw, a_s_addr, a_s_wdata, a_busy, a_grant,
                                   a_m0_ack, a_m1_ack, a_m0_rdata, a_m1_rdata}), 256'(0));
    a_m0_strobe = 1'b0;
    a_m0_addr   = '0;
    @(negedge clk);
    a_rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("a_post_rst_c%0d", c), 256'({a_m0_ack, a_m1_ack, a_busy, a_s_strobe}),
            256'(0));
      @(negedge clk);
    end

    // Fresh request after reset follows cycle-0 timing.
    a_m0_strobe = 1'b1; a_m0_addr = 32'h600;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("a_fresh_c%0d", c),
            256'({a_s_strobe, a_s_addr, a_grant, a_busy, a_m0_ack, a_m1_ack}),
            256'({(c == 1), 32'h600, 1'b0, (c <= 3), (c == 3), 1'b0}));
      if (c == 3) begin
        check("a_fresh_rdata", 256'(a_m0_rdata), 256'(32'hDEADB9EF));
        a_m0_strobe = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tenyr_bus_arbiter.md
Name: tenyr_bus_arbiter

Overview:
- Shares one single-port data memory between two bus masters: m0 is the Core data port, m1 is a DMA/debug requester.
- Each master has a strobe/ack handshake with a registered read-data return.
- The arbiter serialises accesses, drives the memory-side strobe/rw/addr/wdata and returns read data to the winner.
- Round-robin or fixed priority, selected by parameter; memory read latency is fixed by parameter.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- LATENCY, 1, cycles from s_strobe to valid s_rdata; legal range 1..15.
- FIXED_PRIO, 0, 0 = round-robin; 1 = m0 always wins ties.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- m0_strobe  in  1  m0 request; held until m0_ack
- m0_rw  in  1  1 = write, 0 = read
- m0_addr  in  ADDR_W  m0 address
- m0_wdata  in  DATA_W  m0 write data
- m0_ack  out  1  one-cycle completion pulse
- m0_rdata  out  DATA_W  read data; valid while m0_ack = 1
- m1_strobe, m1_rw, m1_addr, m1_wdata, m1_ack, m1_rdata: same as m0 for master 1
- s_strobe  out  1  memory access pulse
- s_rw  out  1  memory write enable
- s_addr  out  ADDR_W  memory address
- s_wdata  out  DATA_W  memory write data
- s_rdata  in  DATA_W  memory read data
- busy  out  1  high in any state other than IDLE
- grant  out  1  index of the current or most recent owner

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - state = IDLE.
  - All outputs 0, including both rdata buses, s_* and grant.
  - Round-robin pointer favours m0.
  - An access in flight is abandoned; no ack is ever issued for it.
- All outputs are registered. No combinational path runs from any input to any output.
- States are IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - No strobe: stay in IDLE.
  - One strobe: grant that master.
  - Both strobes:
    - FIXED_PRIO = 1: m0 wins.
    - FIXED_PRIO = 0: the master not granted last time wins.
  - On a grant: latch grant, rw, addr and wdata from the winner, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - s_strobe = 1 with the latched s_rw, s_addr and s_wdata.
  - Load the latency counter with LATENCY.
  - Go to WAIT.
- WAIT:
  - s_strobe = 0.
  - Counter decrements each cycle.
  - In the cycle the counter reaches 1: capture s_rdata into the owner's rdata register and go to ACK.
  - Writes also pass through WAIT for the full LATENCY cycles, giving uniform timing. On a write, the captured value is don't-care and is not written to the owner's rdata register.
- ACK (1 cycle):
  - Owner's ack = 1; its rdata holds the captured value.
  - Update the round-robin pointer to the current owner.
  - Go to IDLE.
- Timing: strobe first seen at cycle 0 → s_strobe at cycle 1 → s_rdata sampled at cycle 1+LATENCY → ack at cycle 2+LATENCY. Back-to-back throughput is one access per LATENCY+3 cycles.
- s_addr, s_rw and s_wdata hold their values after ISSUE until the next grant; only s_strobe pulses.
- rdata of each master holds its last value until that master's next read completes.
- Master rules:
  - A master must hold strobe, rw, addr and wdata stable until ack. The arbiter samples them only in IDLE.
  - A strobe still high in the cycle after ack is a new request.
- A non-owner's strobe arriving or dropping during ISSUE/WAIT/ACK is ignored until IDLE. A strobe that drops before IDLE is lost, with no error.
- The owner dropping strobe mid-access does not cancel it; ack is still issued.
- Starvation bound (FIXED_PRIO = 0): a continuously requesting master waits at most one other access.
- LATENCY outside 1..15 is a configuration error: elaboration-time assertion.
- Exactly one of m0_ack or m1_ack is ever high in a cycle. grant never changes outside IDLE→ISSUE.

Decomposition:
- Package tenyr_bus_pkg holds:
  - state encoding localparams: IDLE = 0, ISSUE = 1, WAIT = 2, ACK = 3
  - bus width defaults
  - latency counter width CNT_W = 4
- Sub-module tenyr_rr_pick: a purely combinational two-requester picker.
  - Inputs: req[1:0], last, fixed.
  - Outputs: win, any.
  - Reused by a future instruction/data port arbiter.

Test Plan:
- Single read, LATENCY = 1: m0 read from address 0x100; memory returns 0xDEADBEEF at cycle 2 → s_strobe at cycle 1 with s_rw = 0 and s_addr = 0x100; m0_ack and m0_rdata = 0xDEADBEEF at cycle 3; busy falls at cycle 4.
- Write with LATENCY = 3: m1 writes 0x12345678 to address 0x20 → s_strobe = 1 and s_rw = 1 for exactly 1 cycle; m1_ack at cycle 5; m1_rdata unchanged.
- Simultaneous requests, FIXED_PRIO = 0, both held: grant order m0, m1, m0, m1 over 4 accesses; acks spaced LATENCY+3 cycles apart.
- Simultaneous requests, FIXED_PRIO = 1, m0 re-requests immediately after each ack: m0 served 3 times in a row; m1 waits until m0 drops its strobe.
- Reset mid-operation: assert reset_n = 0 during WAIT of an m0 read → all outputs 0 asynchronously; no m0_ack after release; the next request behaves as a fresh cycle-0 request.
- Owner drops strobe during WAIT: m1 strobe falls in the cycle after ISSUE → m1_ack is still issued at cycle 2+LATENCY; no extra s_strobe occurs.
